// File: rtl/decode_stream_if.sv
// -----------------------------------------------------------------------------
// decode_stream_if
// Bundles the two handshakes of the bit-stream decoder front end:
//   * word side   : in_data / in_valid / in_last from upstream, in_ack back
//   * stream side : stream_data / stream_valid to the decoder,
//                   stream_width / stream_ack back from the decoder
// Modports:
//   master : the environment (word producer plus bit consumer)
//   slave  : the decode_stream block itself
// -----------------------------------------------------------------------------
interface decode_stream_if #(
  parameter int IW = 32
);
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ack;
  logic [12:0]   stream_data;
  logic          stream_valid;
  logic [3:0]    stream_width;
  logic          stream_ack;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ack,
    input  stream_data,
    input  stream_valid,
    output stream_width,
    output stream_ack
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ack,
    output stream_data,
    output stream_valid,
    input  stream_width,
    input  stream_ack
  );
endinterface

// File: rtl/decode_stream.sv
// -----------------------------------------------------------------------------
// decode_stream
// Bit-buffer front end for a variable-length decoder. 32-bit compressed words
// are packed MSB-first into a 64-bit buffer; the decoder looks at the oldest
// 13 bits and consumes 0..13 of them per cycle.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   ce         : start pulse, honoured only while idle (also clears err)
//   stop       : abort / end of stream, highest priority, returns to idle
//   err        : sticky protocol error (bad consume width)
//   busy       : high whenever not idle
//   s          : word handshake and stream handshake (slave modport)
// Buffer invariant: the cnt valid bits occupy bit_buf[63:64-cnt] and every
// bit below them is zero, so a plain left shift always refills with zeros.
// -----------------------------------------------------------------------------
module decode_stream #(
  parameter int BW = 64,
  parameter int IW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             stop,
  output logic             err,
  output logic             busy,
  decode_stream_if.slave   s
);

  localparam int          SW        = 13;
  localparam logic [6:0]  WORD_BITS = 7'(IW);
  localparam logic [6:0]  VIEW_BITS = 7'(SW);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_buf_q, bit_buf_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            err_q, err_d;

  // Combinational views of the registered state
  logic            in_ack_c;
  logic            stream_valid_c;
  logic            busy_c;

  // Consumption / load datapath
  logic            take;
  logic            width_bad;
  logic            accept;
  logic [6:0]      w_req;
  logic [6:0]      w_eff;
  logic [6:0]      rem;
  logic [BW-1:0]   shifted;
  logic [BW-1:0]   word_ext;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: bit buffer, fill count and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_buf_q <= {BW{1'b0}};
      cnt_q     <= 7'd0;
      err_q     <= 1'b0;
    end else begin
      bit_buf_q <= bit_buf_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic; stop overrides every other event
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ce) state_d = S_RUN;
          else    state_d = S_IDLE;
        end
        S_RUN: begin
          if (accept && s.in_last) state_d = S_DRAIN;
          else                     state_d = S_RUN;
        end
        S_DRAIN: begin
          state_d = S_DRAIN;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State-decoded outputs; in_ack depends on registered state only
  always_comb begin
    in_ack_c       = 1'b0;
    stream_valid_c = 1'b0;
    busy_c         = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ack_c       = 1'b0;
        stream_valid_c = 1'b0;
        busy_c         = 1'b0;
      end
      S_RUN: begin
        in_ack_c       = (cnt_q <= WORD_BITS);
        stream_valid_c = (cnt_q >= VIEW_BITS);
        busy_c         = 1'b1;
      end
      S_DRAIN: begin
        in_ack_c       = 1'b0;
        stream_valid_c = (cnt_q != 7'd0);
        busy_c         = 1'b1;
      end
      default: begin
        in_ack_c       = 1'b0;
        stream_valid_c = 1'b0;
        busy_c         = 1'b0;
      end
    endcase
  end

  // Effective consume width. A bad width sets err and consumes nothing. In
  // drain, a width beyond the fill level is legal and simply empties the
  // buffer, so the shift amount saturates at cnt.
  always_comb begin
    take      = s.stream_ack & stream_valid_c;
    w_req     = {3'b000, s.stream_width};
    width_bad = 1'b0;
    w_eff     = 7'd0;
    if (take) begin
      width_bad = (s.stream_width > 4'd13) ||
                  ((state_q == S_RUN) && (w_req > cnt_q));
    end else begin
      width_bad = 1'b0;
    end
    if (take && !width_bad) begin
      if (w_req > cnt_q) w_eff = cnt_q;
      else               w_eff = w_req;
    end else begin
      w_eff = 7'd0;
    end
    accept   = s.in_valid & in_ack_c;
    rem      = cnt_q - w_eff;
    shifted  = bit_buf_q << w_eff;
    // New word lands directly below the bits that survive this cycle's
    // consumption; rem never exceeds 32 when a word is accepted.
    word_ext = {s.in_data, {(BW-IW){1'b0}}} >> rem;
  end

  // Next buffer / count / error; entering idle flushes everything
  always_comb begin
    bit_buf_d = bit_buf_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    if (stop) begin
      bit_buf_d = {BW{1'b0}};
      cnt_d     = 7'd0;
      err_d     = err_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          bit_buf_d = {BW{1'b0}};
          cnt_d     = 7'd0;
          if (ce) err_d = 1'b0;
          else    err_d = err_q;
        end
        S_RUN, S_DRAIN: begin
          err_d = err_q | width_bad;
          if (accept) begin
            bit_buf_d = shifted | word_ext;
            cnt_d     = rem + WORD_BITS;
          end else begin
            bit_buf_d = shifted;
            cnt_d     = rem;
          end
        end
        default: begin
          bit_buf_d = {BW{1'b0}};
          cnt_d     = 7'd0;
          err_d     = err_q;
        end
      endcase
    end
  end

  assign s.stream_data  = bit_buf_q[BW-1 -: SW];
  assign s.stream_valid = stream_valid_c;
  assign s.in_ack       = in_ack_c;
  assign busy           = busy_c;
  assign err            = err_q;

endmodule

// File: doc/decode_stream.md
DECODE_STREAM -- requirements
Module: decode_stream

Interface
REQ-001 Parameter BW, default 64, SHALL set the bit-buffer depth in bits; legal values are 64 only.
REQ-002 Parameter IW, default 32, SHALL set the input word width; it is fixed at 32.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 ce  input  1  SHALL be a one-cycle start pulse, honoured only in S_IDLE.
REQ-006 stop  input  1  SHALL abort or finish the stream and return to S_IDLE; it is driven from the decoder's out_done.
REQ-007 in_data  input  32  SHALL carry a compressed word; in_data[31] is the first bit of the stream.
REQ-008 in_valid  input  1  SHALL qualify in_data.
REQ-009 in_last  input  1  SHALL mark the final word, qualified by in_valid.
REQ-010 in_ack  output  1  SHALL indicate that the word is accepted this cycle when in_valid&in_ack.
REQ-011 stream_data  output  13  SHALL carry the next 13 unconsumed bits, MSB-aligned (stream_data[12] is the oldest bit).
REQ-012 stream_valid  output  1  SHALL indicate that stream_data is usable.
REQ-013 stream_width  input  4  SHALL give the number of bits consumed on ack, in the range 0..13.
REQ-014 stream_ack  input  1  SHALL consume stream_width bits at the clock edge.
REQ-015 err  output  1  SHALL be a sticky protocol-error flag.
REQ-016 busy  output  1  SHALL be high whenever the state is not S_IDLE.

Function
REQ-017 The state machine SHALL have three states: S_IDLE, S_RUN and S_DRAIN. Transitions: S_IDLE->S_RUN on ce; S_RUN->S_DRAIN on an accepted word with in_last=1; S_RUN or S_DRAIN->S_IDLE on stop.
REQ-018 stop SHALL have priority over every other event, and entry to S_IDLE SHALL clear the buffer, cnt and all pending transfers.
REQ-019 State SHALL be a 64-bit buffer buf plus a 7-bit count cnt (0..64); valid bits occupy buf[63:64-cnt], and all bits below them are zero.
REQ-020 stream_data SHALL equal buf[63:51] combinationally.
REQ-021 stream_valid SHALL be (S_RUN and cnt>=13) or (S_DRAIN and cnt>0); in S_DRAIN the missing low bits read as 0.
REQ-022 in_ack SHALL be S_RUN and cnt<=32, be registered-state-only (no path from stream_ack), and be 0 in S_IDLE and S_DRAIN.
REQ-023 Consumption: the effective width w SHALL be stream_width when stream_ack&stream_valid, else 0; stream_ack while stream_valid=0 SHALL be ignored.
REQ-024 When a word is accepted and consumption happens in the same cycle, the update SHALL be buf_next = (buf<<w) | ({in_data,32'h0} >> (cnt-w)) and cnt_next = cnt-w+32.
REQ-025 Without a word the update SHALL be buf<<w and cnt-w; without consumption it SHALL be w=0.
REQ-026 In S_DRAIN, w>cnt SHALL be legal: buf shifts to zero and cnt saturates at 0, with no err.
REQ-027 err SHALL set on ack&stream_valid with stream_width>13.
REQ-028 err SHALL set on ack&stream_valid with stream_width>cnt in S_RUN; in that case the buffer is unchanged.
REQ-029 err SHALL be cleared only by reset or by ce in S_IDLE.
REQ-030 A word accepted with in_last=1 SHALL still be loaded; later in_valid SHALL be ignored until the next ce.
REQ-031 Latency SHALL be one cycle: an accepted word is visible on stream_data the cycle after in_ack&in_valid, and a consumed value is replaced the next cycle.
REQ-032 Throughput SHALL be sustained: 13-bit consumption every cycle at one input word per 32 bits.

Reset
REQ-033 While rst_n=0 the block SHALL force state=S_IDLE, buf=0, cnt=0, err=0, in_ack=0, stream_valid=0, stream_data=0 and busy=0, asynchronously.
REQ-034 Reset deasserted mid-stream SHALL leave the block in S_IDLE with no partial word retained; the upstream must restart with ce.

Verification
REQ-035 Load: ce, then in_data=32'hC000_0000 with in_last=0 -> next cycle stream_data=13'h1800, stream_valid=1, cnt=32, in_ack=1.
REQ-036 Back-to-back consumption: words 32'h1234_5678 then 32'h9ABC_DEF0, with width 9 acked every cycle -> successive stream_data[12:4] match a bit-serial reference model and there are no bubbles while input is available.
REQ-037 Boundary: cnt=33 with in_valid=1 -> in_ack=0; after ack of width 13 (cnt=20) -> in_ack=1 and the word concatenates at bit 20.
REQ-038 Drain: last word 32'hC000_0000 with in_last=1, 23 bits consumed -> cnt=9, stream_valid=1, stream_data=13'h0000; ack width 13 -> cnt=0, stream_valid=0, err=0.
REQ-039 Error: in S_RUN with cnt=13, ack width 14 -> err=1 and cnt stays 13; err persists until ce in S_IDLE.
REQ-040 Abort: stop asserted in the same cycle as an accepted word and an ack -> the next cycle shows S_IDLE, cnt=0, stream_valid=0, busy=0; asynchronous rst_n low mid-word -> all outputs 0 immediately.
